forward_source_pipe: RTL

Producer side of the EX-stage forwarding path. It registers each EX-stage result through the MEM and WB stages and drives the forwarding buses that the EX-stage operand mux consumes: MEM-stage result/destination, WB-stage result/destination, and load data with its valid flag. It also handles the data-memory load handshake and raises the load-use and memory-wait stall requests that freeze the front end. It sits between the ALU output, the data memory port and the register file write port.

---
 rtl/forward_source_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/forward_source_pipe.sv
// EX-stage forwarding producer: carries ALU/load results through MEM and WB,
// runs the data-memory load handshake and raises the load-use and memory-wait stalls.
module forward_source_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_reg_write,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_dest,
    input  logic [31:0] ex_result,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        fwd_mem_valid,
    output logic [4:0]  fwd_mem_dest,
    output logic [31:0] fwd_mem_result,
    output logic        fwd_wb_valid,
    output logic [4:0]  fwd_wb_dest,
    output logic [31:0] fwd_wb_result,
    output logic        fwd_load,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_id,
    output logic        stall_all,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state, state_n;
    logic        adv;

    logic        mem_valid;
    logic        mem_is_load;
    logic        mem_ld_pending;
    logic [4:0]  mem_dest;
    logic [31:0] mem_result;

    logic        wb_valid;
    logic        wb_is_load;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    // Load handshake: the first MEM cycle of a load already stalls if no ack arrives
    always_comb begin
        state_n   = state;
        mem_req   = 1'b0;
        stall_all = 1'b0;
        case (state)
            ST_RUN: begin
                mem_req = mem_ld_pending;
                if (mem_ld_pending && !mem_ack) begin
                    stall_all = 1'b1;
                    state_n   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_req   = 1'b1;
                stall_all = !mem_ack;
                if (mem_ack)
                    state_n = ST_RUN;
            end
            default: state_n = ST_RUN;
        endcase
    end

    assign adv = !stall_all;

    always_comb begin
        stall_id = 1'b0;
        if (ex_valid && ex_is_load && ex_reg_write && (ex_dest != 5'd0))
            stall_id = (id_uses_rs && (id_rs == ex_dest)) ||
                       (id_uses_rt && (id_rt == ex_dest));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_RUN;
        else
            state <= state_n;
    end

    // A load to r0 still performs its access; only the write-back is suppressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_is_load    <= 1'b0;
            mem_ld_pending <= 1'b0;
            mem_dest       <= '0;
            mem_result     <= '0;
        end else if (adv) begin
            mem_valid      <= ex_valid && ex_reg_write && (ex_dest != 5'd0) && !flush;
            mem_is_load    <= ex_is_load;
            mem_ld_pending <= ex_valid && ex_is_load && !flush;
            mem_dest       <= ex_dest;
            mem_result     <= ex_result;
        end
    end

    // WB takes a bubble while stalled so each instruction writes exactly once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_is_load <= 1'b0;
            wb_dest    <= '0;
            wb_data    <= '0;
        end else if (adv) begin
            wb_valid   <= mem_valid;
            wb_is_load <= mem_is_load;
            wb_dest    <= mem_dest;
            wb_data    <= mem_is_load ? mem_rdata : mem_result;
        end else begin
            wb_valid   <= 1'b0;
            wb_is_load <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if ((stall_id || stall_all) && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 16'd1;
    end

    assign mem_addr       = mem_result;
    assign fwd_mem_valid  = mem_valid && !mem_is_load;
    assign fwd_mem_dest   = mem_dest;
    assign fwd_mem_result = mem_result;

    assign rf_we          = wb_valid;
    assign rf_waddr       = wb_dest;
    assign rf_wdata       = wb_data;
    assign fwd_wb_valid   = wb_valid;
    assign fwd_wb_dest    = wb_dest;
    assign fwd_wb_result  = wb_data;
    assign fwd_load       = wb_is_load;

endmodule
